// File: rtl/univ_shift_reg.sv
// univ_shift_reg: parametrised universal shift register.
// Supports hold, shift right/left with serial input, parallel load and,
// when SHREG_ROTATE_EN is defined, rotate right/left.
// A single step is applied under EN while idle. A multi-step burst is
// started with START/AMT and reported through BUSY and a one-cycle DONE pulse.
// Build option: define SHREG_ROTATE_EN to enable MODE 100/101 rotates.
// Without it those codes decode as hold and no rotate logic exists.
module univ_shift_reg #(
  parameter int             N         = 32,
  parameter int             CNT_W     = 6,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [N-1:0]     D,
  input  logic             SIN,
  input  logic             START,
  input  logic [CNT_W-1:0] AMT,
  output logic [N-1:0]     Q,
  output logic             SOUT_R,
  output logic             SOUT_L,
  output logic             BUSY,
  output logic             DONE
);

  // Operation encodings on MODE
  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROTR = 3'b100;
  localparam logic [2:0] OP_ROTL = 3'b101;

  // Count value identifying the final step of a burst
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [N-1:0]     q_reg, q_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [2:0]       op_reg, op_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Next value of the register for one step of the given operation.
  // Reserved codes, hold and (without rotate support) rotate codes keep cur.
  function automatic logic [N-1:0] apply_op(
    input logic [2:0]   op,
    input logic [N-1:0] cur,
    input logic         sin_bit,
    input logic [N-1:0] load_data
  );
    logic [N-1:0] res;
    res = cur;
    case (op)
      OP_HOLD: res = cur;
      OP_SHR:  res = {sin_bit, cur[N-1:1]};
      OP_SHL:  res = {cur[N-2:0], sin_bit};
      OP_LOAD: res = load_data;
`ifdef SHREG_ROTATE_EN
      OP_ROTR: res = {cur[0], cur[N-1:1]};
      OP_ROTL: res = {cur[N-2:0], cur[N-1]};
`endif
      default: res = cur;
    endcase
    return res;
  endfunction

  // True for operations that make sense repeated as a burst (shift/rotate).
  // Everything else takes the immediate DONE path on START.
  function automatic logic is_burst_op(input logic [2:0] op);
    logic res;
    res = 1'b0;
    case (op)
      OP_SHR:  res = 1'b1;
      OP_SHL:  res = 1'b1;
`ifdef SHREG_ROTATE_EN
      OP_ROTR: res = 1'b1;
      OP_ROTL: res = 1'b1;
`endif
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Next-state, datapath and handshake decode
  always_comb begin
    state_next = state_reg;
    q_next     = q_reg;
    count_next = count_reg;
    op_next    = op_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (START) begin
          // START has priority over EN and never steps at the accept edge
          if (is_burst_op(MODE) && (AMT != '0)) begin
            op_next    = MODE;
            count_next = AMT;
            busy_next  = 1'b1;
            state_next = RUN;
          end else begin
            done_next = 1'b1;
          end
        end else if (EN) begin
          q_next = apply_op(MODE, q_reg, SIN, D);
        end
      end

      RUN: begin
        // Latched op only; SIN is the only live input while running
        q_next     = apply_op(op_reg, q_reg, SIN, D);
        count_next = count_reg - CNT_ONE;
        if (count_reg == CNT_ONE) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        busy_next  = 1'b0;
        count_next = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= IDLE;
      q_reg     <= RESET_VAL;
      count_reg <= '0;
      op_reg    <= OP_HOLD;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign Q      = q_reg;
  assign SOUT_R = q_reg[0];
  assign SOUT_L = q_reg[N-1];
  assign BUSY   = busy_reg;
  assign DONE   = done_reg;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Testbench for univ_shift_reg: directed scenarios plus randomized
// single steps and bursts checked against a behavioural register model.
module tb_univ_shift_reg;

  localparam int N     = 32;
  localparam int CNT_W = 6;
`ifdef SHREG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       mode;
  logic [N-1:0]     d;
  logic             sin;
  logic             start;
  logic [CNT_W-1:0] amt;
  logic [N-1:0]     q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] model_q;

  univ_shift_reg #(.N(N), .CNT_W(CNT_W), .RESET_VAL('0)) dut (
    .CLK(clk), .RESET(rst), .EN(en), .MODE(mode), .D(d), .SIN(sin),
    .START(start), .AMT(amt), .Q(q), .SOUT_R(sout_r), .SOUT_L(sout_l),
    .BUSY(busy), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: one step of an operation, written as plain arithmetic
  function automatic logic [N-1:0] model_step(input logic [2:0] op, input logic [N-1:0] cur,
                                              input logic s, input logic [N-1:0] ld);
    logic [N-1:0] s_word;
    logic [N-1:0] lsb_word;
    logic [N-1:0] msb_word;
    s_word   = '0; s_word[0]   = s;
    lsb_word = '0; lsb_word[0] = cur[0];
    msb_word = '0; msb_word[0] = cur[N-1];
    case (op)
      3'd1: return (cur >> 1) | (s_word << (N-1));
      3'd2: return (cur << 1) | s_word;
      3'd3: return ld;
      3'd4: return ROT ? ((cur >> 1) | (lsb_word << (N-1))) : cur;
      3'd5: return ROT ? ((cur << 1) | msb_word) : cur;
      default: return cur;
    endcase
  endfunction

  function automatic bit model_is_burst(input logic [2:0] op);
    return (op == 3'd1) || (op == 3'd2) || (ROT && (op == 3'd4 || op == 3'd5));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with no request; model is unchanged
  task automatic idle();
    en = 1'b0; start = 1'b0;
    tick();
  endtask

  // Single-step load through EN
  task automatic load(input logic [N-1:0] val);
    en = 1'b1; start = 1'b0; mode = 3'd3; d = val;
    tick();
    en = 1'b0;
    model_q = val;
  endtask

  // Burst request; noisy toggles the ignored inputs while running.
  // Leaves the bench in the cycle where DONE should be high.
  task automatic do_burst(input logic [2:0] bmode, input logic [CNT_W-1:0] bamt,
                          input bit noisy, input bit rand_sin);
    start = 1'b1; mode = bmode; amt = bamt;
    en = 1'($urandom); d = N'($urandom); sin = rand_sin ? 1'($urandom) : 1'b0;
    tick();
    start = 1'b0;
    if (!model_is_burst(bmode) || bamt == '0) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b1 || q !== model_q) begin
        errors++;
        $display("FAIL burst_nop: busy=%b done=%b q=%h, expected busy=0 done=1 q=%h",
                 busy, done, q, model_q);
      end
    end else begin
      for (int k = 0; k < int'(bamt); k++) begin
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          errors++;
          $display("FAIL burst_busy: step %0d busy=%b done=%b, expected busy=1 done=0",
                   k, busy, done);
        end
        sin = rand_sin ? 1'($urandom) : 1'b0;
        if (noisy) begin
          en = 1'($urandom); mode = 3'($urandom); d = N'($urandom); start = 1'($urandom);
        end
        tick();
        model_q = model_step(bmode, model_q, sin, '0);
        checks++;
        if (q !== model_q) begin
          errors++;
          $display("FAIL burst_q: step %0d q=%h, expected %h", k, q, model_q);
        end
      end
      start = 1'b0; en = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL burst_done: busy=%b done=%b, expected busy=0 done=1", busy, done);
      end
    end
    $display("burst mode=%0d amt=%0d q=%h", bmode, bamt, q);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    model_q = '0;
    checks++;
    if (q !== 32'h0) begin errors++; $display("FAIL reset_q: q=%h, expected 0", q); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b, expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: done=%b, expected 0", done); end
    checks++;
    if (sout_r !== 1'b0 || sout_l !== 1'b0) begin
      errors++; $display("FAIL reset_sout: sout_r=%b sout_l=%b, expected 0 0", sout_r, sout_l);
    end
    rst = 1'b0;
    $display("reset q=%h", q);
  endtask

  task automatic test_load_hold();
    load(32'hAFAFAFAF);
    checks++;
    if (q !== 32'hAFAFAFAF) begin errors++; $display("FAIL load: q=%h, expected afafafaf", q); end
    for (int i = 0; i < 5; i++) begin
      mode = 3'($urandom); d = N'($urandom);
      idle();
      checks++;
      if (q !== 32'hAFAFAFAF) begin errors++; $display("FAIL hold: cycle %0d q=%h, expected afafafaf", i, q); end
    end
    $display("load/hold q=%h", q);
  endtask

  task automatic test_single_steps();
    load(32'h00000001);
    en = 1'b1; mode = 3'd1; sin = 1'b1;
    tick();
    en = 1'b0;
    model_q = 32'h80000000;
    checks++;
    if (q !== 32'h80000000 || sout_l !== 1'b1 || sout_r !== 1'b0) begin
      errors++; $display("FAIL step_shr: q=%h sout_l=%b sout_r=%b, expected 80000000 1 0", q, sout_l, sout_r);
    end
    load(32'h80000001);
    en = 1'b1; mode = 3'd2; sin = 1'b0;
    tick();
    en = 1'b0;
    model_q = 32'h00000002;
    checks++;
    if (q !== 32'h00000002 || sout_l !== 1'b0 || sout_r !== 1'b0) begin
      errors++; $display("FAIL step_shl: q=%h sout_l=%b sout_r=%b, expected 00000002 0 0", q, sout_l, sout_r);
    end
    $display("single steps q=%h", q);
  endtask

  task automatic test_burst_shr();
    load(32'hAFAFAFAF);
    do_burst(3'd1, 6'd4, 1'b1, 1'b0);
    checks++;
    if (q !== 32'h0AFAFAFA) begin errors++; $display("FAIL burst_shr: q=%h, expected 0afafafa", q); end
    idle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL burst_shr_clear: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_burst_edge();
    load(32'h5A5A1234);
    do_burst(3'd1, 6'd0, 1'b0, 1'b1);
    checks++;
    if (q !== 32'h5A5A1234) begin errors++; $display("FAIL amt0_q: q=%h, expected 5a5a1234", q); end
    idle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL amt0_clear: done=%b busy=%b, expected 0 0", done, busy);
    end
    // Abort an 8-step burst after two steps
    start = 1'b1; mode = 3'd1; amt = 6'd8; sin = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    model_q = '0;
    checks++;
    if (q !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort: q=%h busy=%b done=%b, expected 0 0 0", q, busy, done);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || q !== 32'h0) begin
        errors++; $display("FAIL abort_after: cycle %0d q=%h busy=%b done=%b, expected 0 0 0", i, q, busy, done);
      end
    end
    $display("abort q=%h", q);
  endtask

  task automatic test_rotate();
    logic [N-1:0] exp_q;
    exp_q = ROT ? 32'h34567812 : 32'h12345678;
    load(32'h12345678);
    do_burst(3'd5, 6'd8, 1'b0, 1'b1);
    checks++;
    if (q !== exp_q) begin errors++; $display("FAIL rotl_burst: q=%h, expected %h", q, exp_q); end
    idle();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL rotl_clear: done=%b, expected 0", done); end
  endtask

  task automatic test_back_to_back();
    load(N'($urandom));
    do_burst(3'd1, 6'($urandom_range(1, 10)), 1'b1, 1'b1);
    do_burst(3'd2, 6'($urandom_range(1, 10)), 1'b1, 1'b1);
    do_burst(3'd3, 6'($urandom_range(1, 10)), 1'b0, 1'b1);
    do_burst(3'd2, 6'($urandom_range(33, 40)), 1'b0, 1'b1);
    idle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || q !== model_q) begin
      errors++; $display("FAIL b2b_end: q=%h busy=%b done=%b, expected %h 0 0", q, busy, done, model_q);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        do_burst(3'($urandom), 6'($urandom_range(0, 40)), 1'b1, 1'b1);
        idle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || q !== model_q) begin
          errors++; $display("FAIL rand_burst_end: q=%h busy=%b done=%b, expected %h 0 0", q, busy, done, model_q);
        end
      end else begin
        en = 1'($urandom); mode = 3'($urandom); d = N'($urandom); sin = 1'($urandom); start = 1'b0;
        tick();
        if (en) model_q = model_step(mode, model_q, sin, d);
        checks++;
        if (q !== model_q || sout_r !== model_q[0] || sout_l !== model_q[N-1] ||
            busy !== 1'b0 || done !== 1'b0) begin
          errors++;
          $display("FAIL rand_step: en=%b mode=%0d q=%h sout_r=%b sout_l=%b busy=%b done=%b, expected q=%h",
                   en, mode, q, sout_r, sout_l, busy, done, model_q);
        end
        $display("step en=%b mode=%0d sin=%b q=%h", en, mode, sin, q);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; d = '0; sin = 1'b0; start = 1'b0; amt = '0;
    model_q = '0;
    test_reset();
    test_load_hold();
    test_single_steps();
    test_burst_shr();
    test_burst_edge();
    test_rotate();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
